// File: rtl/serial_subtractor_nbit_pkg.sv
// Shared definitions for the bit-serial subtractor: controller states and default width.
package serial_subtractor_nbit_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor, LSB first, with valid/ready handshakes on both sides.
module serial_subtractor_nbit
    import serial_subtractor_nbit_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int          CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic          br;
    logic [CW-1:0] cnt;
    logic          d_bit;
    logic          br_next;

    full_subtractor_1bit u_bit (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_next)
    );

    // The minuend register doubles as the result register: each difference bit
    // enters at the MSB as the consumed minuend bit leaves at the LSB.
    // NOTE: non-blocking assignments keep every register sampling pre-edge values,
    // so the shift, borrow and counter updates below see a consistent snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state, including the datapath shift registers, is reset so an
        // aborted operation can never leak partial bits into a later result.
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            bout      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        br       <= bin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh <= {d_bit, a_sh[N-1:1]};
                    b_sh <= {1'b0, b_sh[N-1:1]};
                    br   <= br_next;
                    if (cnt == LAST) begin
                        diff      <= {d_bit, a_sh[N-1:1]};
                        bout      <= br_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor_nbit.md
SERIAL_SUBTRACTOR_NBIT -- requirements
Module: serial_subtractor_nbit

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand and difference width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port a  input  N  minuend, sampled on accept.
REQ-005 SHALL have port b  input  N  subtrahend, sampled on accept.
REQ-006 SHALL have port bin  input  1  borrow-in, sampled on accept.
REQ-007 SHALL have port in_valid  input  1  operands present.
REQ-008 SHALL have port in_ready  output  1  block can accept operands.
REQ-009 SHALL have port diff  output  N  difference result.
REQ-010 SHALL have port bout  output  1  borrow-out result.
REQ-011 SHALL have port out_valid  output  1  diff/bout hold a completed result.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.

Function
REQ-013 SHALL compute {bout,diff} = (a - b - bin) mod 2^(N+1); bout=1 iff a < b + bin (unsigned).
REQ-014 SHALL use an FSM with states IDLE, SHIFT, DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; accept when in_valid && in_ready: latch a, b, borrow register <= bin, bit counter <= 0, go SHIFT.
REQ-016 SHIFT: one bit per cycle, LSB first: d = a0^b0^br; br' = (~a0&b0) | (~(a0^b0)&br); d shifted into result MSB, operands shifted right, counter increments.
REQ-017 SHIFT SHALL last exactly N cycles; on the cycle counter == N-1, go DONE.
REQ-018 out_valid SHALL rise exactly N clock edges after the accepting edge; diff = result register, bout = final borrow.
REQ-019 DONE: out_valid=1, in_ready=0; diff/bout stable until out_valid && out_ready, then go IDLE on that edge.
REQ-020 in_ready SHALL be 0 in SHIFT and DONE; in_valid in those states is ignored and does not alter the operation.
REQ-021 diff/bout SHALL hold the last completed result outside DONE until the next completion overwrites them.
REQ-022 Counter SHALL be ceil(log2(N)) bits wide, never wrap inside one operation.
REQ-023 Back-to-back: an accept may occur the cycle after the DONE->IDLE handoff; throughput one operation per N+2 cycles.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, counter 0, shift/borrow registers 0, diff=0, bout=0, out_valid=0, in_ready=1.
REQ-025 Reset mid-SHIFT or mid-DONE SHALL abort the operation with no partial result emitted.
REQ-026 First accept is allowed on the first rising edge with rst_n high.

Structure
REQ-027 Shared package SHALL hold the FSM state enumeration (IDLE, SHIFT, DONE) and the default width constant 8.
REQ-028 One sub-module, full_subtractor_1bit (a, b, bin -> d, bout, combinational), SHALL implement the per-bit logic of REQ-016.
REQ-029 RTL SHALL be synthesisable, one clocked process plus combinational next-state logic, no latches.

Verification
REQ-030 a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, out_valid exactly 8 edges after accept.
REQ-031 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
REQ-032 a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0; a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
REQ-033 out_ready held low 5 cycles in DONE, in_valid high with new operands -> out_valid, diff, bout stable, in_ready=0, new operands not captured.
REQ-034 rst_n pulsed low at counter=3 of SHIFT -> all outputs 0, in_ready=1 asynchronously; next operation a=0x10, b=0x01, bin=0 -> diff=0x0F, bout=0.
REQ-035 200 random {a,b,bin} with random out_ready stalls -> every {bout,diff} equals (a - b - bin) mod 512; bench reports total mismatches, zero required.
